// File: rtl/odd_sel_if.sv
// Word-in / result-out bundle for the odd_sel parity checker.
// master drives the word under check, slave returns the registered result.
interface odd_sel_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
);
  logic [DATA_W-1:0] data;
  logic              sel;
  logic              in_valid;
  logic              check;
  logic [CNT_W-1:0]  ones_cnt;
  logic              out_valid;

  modport master (output data, sel, in_valid, input check, ones_cnt, out_valid);
  modport slave  (input data, sel, in_valid, output check, ones_cnt, out_valid);
endinterface

// File: rtl/odd_sel.sv
// odd_sel: two-stage registered parity / popcount checker.
// Stage 1 registers per-byte popcounts and parities, stage 2 reduces them.
// Optional sticky error flag: define ODD_SEL_STICKY_ERR_EN to add err_clr/err_sticky.

// One byte lane: popcount and XOR parity of up to 8 bits.
module odd_sel_lane #(
  parameter int W = 8
) (
  input  logic [W-1:0] d,
  output logic [3:0]   cnt,
  output logic         par
);
  // ripple count of set bits; parity is the XOR reduction
  always_comb begin
    cnt = 4'd0;
    for (int b = 0; b < W; b++) cnt = cnt + {3'd0, d[b]};
    par = ^d;
  end
endmodule

module odd_sel #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef ODD_SEL_STICKY_ERR_EN
  input  logic       err_clr,
  output logic       err_sticky,
`endif
  odd_sel_if.slave   bus
);
  localparam int NUM_B  = (DATA_W + 7) / 8;
  localparam int STAGES = 2;

  logic [NUM_B-1:0][3:0] lane_cnt;
  logic [NUM_B-1:0]      lane_par;
  logic [NUM_B-1:0][3:0] b_cnt;
  logic [NUM_B-1:0]      b_par;
  logic                  s1_sel;
  logic [STAGES-1:0]     vld_pipe;
  logic [CNT_W-1:0]      sum;
  logic                  par;

  // byte lanes; the top lane is partial when DATA_W is not a byte multiple
  for (genvar i = 0; i < NUM_B; i++) begin : g_lane
    localparam int LW = (DATA_W - 8*i) < 8 ? (DATA_W - 8*i) : 8;
    odd_sel_lane #(.W(LW)) u_lane (
      .d   (bus.data[8*i +: LW]),
      .cnt (lane_cnt[i]),
      .par (lane_par[i])
    );
  end

  // valid tags advance every cycle regardless of data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-2:0], bus.in_valid};
  end

  // stage 1: capture lane results and sel, only for valid words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_cnt  <= '0;
      b_par  <= '0;
      s1_sel <= 1'b0;
    end else if (bus.in_valid) begin
      b_cnt  <= lane_cnt;
      b_par  <= lane_par;
      s1_sel <= bus.sel;
    end
  end

  // reduce lane counts and parities
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_B; i++) sum = sum + CNT_W'(b_cnt[i]);
    par = ^b_par;
  end

  // stage 2: results hold their last valid value when the tag is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ones_cnt <= '0;
      bus.check    <= 1'b0;
    end else if (vld_pipe[0]) begin
      bus.ones_cnt <= sum;
      bus.check    <= s1_sel ? par : ~par;
    end
  end

  assign bus.out_valid = vld_pipe[STAGES-1];

`ifdef ODD_SEL_STICKY_ERR_EN
  // latch any failed check until cleared; clear wins over a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            err_sticky <= 1'b0;
    else if (err_clr)                      err_sticky <= 1'b0;
    else if (bus.out_valid && !bus.check)  err_sticky <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_odd_sel.sv
// Directed bench for odd_sel; covers the sticky flag when ODD_SEL_STICKY_ERR_EN is defined.
module tb_odd_sel;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  odd_sel_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

`ifdef ODD_SEL_STICKY_ERR_EN
  logic err_clr = 1'b0;
  logic err_sticky;
`endif

  odd_sel #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef ODD_SEL_STICKY_ERR_EN
    .err_clr    (err_clr),
    .err_sticky (err_sticky),
`endif
    .bus        (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [DATA_W-1:0] d);
    bus.in_valid = v;
    bus.sel      = s;
    bus.data     = d;
  endtask

  task automatic chk(input string name, input logic v, input logic c, input logic [CNT_W-1:0] n);
    n_cmp++;
    if (bus.out_valid !== v || bus.check !== c || bus.ones_cnt !== n) begin
      n_err++;
      $display("FAIL %s: got valid=%b check=%b cnt=%0d, want valid=%b check=%b cnt=%0d",
               name, bus.out_valid, bus.check, bus.ones_cnt, v, c, n);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, '0);
    repeat (2) step();
    chk("reset", 1'b0, 1'b0, 6'd0);
`ifdef ODD_SEL_STICKY_ERR_EN
    n_cmp++;
    if (err_sticky !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sticky: got %b want 0", err_sticky);
    end
`endif
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", 1'b0, 1'b0, 6'd0);
  endtask

  task automatic test_single();
    drive(1'b1, 1'b1, 32'hFF005A1F);
    step();
    drive(1'b0, 1'b0, '0);
    chk("single_latency1", 1'b0, 1'b0, 6'd0);
    step();
    chk("single_FF005A1F", 1'b1, 1'b1, 6'd17);
    step();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] w [4];
    logic [CNT_W-1:0]  cnt [4];
    logic              odd [4];
    w[0] = 32'hFF005A1F; cnt[0] = 6'd17; odd[0] = 1'b1;
    w[1] = 32'hFF825A5F; cnt[1] = 6'd20; odd[1] = 1'b0;
    w[2] = 32'hFF265A6F; cnt[2] = 6'd21; odd[2] = 1'b1;
    w[3] = 32'hFF415A8F; cnt[3] = 6'd19; odd[3] = 1'b1;
    for (int s = 1; s >= 0; s--) begin
      for (int i = 0; i < 5; i++) begin
        if (i < 4) drive(1'b1, s[0], w[i]);
        else       drive(1'b0, 1'b0, '0);
        step();
        if (i >= 1)
          chk($sformatf("b2b_sel%0d_w%0d", s, i-1), 1'b1,
              s[0] ? odd[i-1] : ~odd[i-1], cnt[i-1]);
      end
      step();
      chk($sformatf("b2b_sel%0d_drain", s), 1'b0, s[0] ? odd[3] : ~odd[3], cnt[3]);
    end
  endtask

  task automatic test_boundary();
    logic [DATA_W-1:0] d [4];
    logic              s [4];
    logic [CNT_W-1:0]  n [4];
    logic              c [4];
    d[0] = 32'h0;        s[0] = 1'b0; n[0] = 6'd0;  c[0] = 1'b1;
    d[1] = 32'h0;        s[1] = 1'b1; n[1] = 6'd0;  c[1] = 1'b0;
    d[2] = 32'hFFFFFFFF; s[2] = 1'b0; n[2] = 6'd32; c[2] = 1'b1;
    d[3] = 32'hFFFFFFFF; s[3] = 1'b1; n[3] = 6'd32; c[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1'b1, s[i], d[i]);
      else       drive(1'b0, 1'b0, '0);
      step();
      if (i >= 1) chk($sformatf("boundary_%0d", i-1), 1'b1, c[i-1], n[i-1]);
    end
    step();
  endtask

  task automatic test_pulse_hold();
    drive(1'b1, 1'b1, 32'hFF265A6F);
    step();
    drive(1'b0, 1'b0, 32'h0);
    step();
    chk("pulse_valid", 1'b1, 1'b1, 6'd21);
    step();
    chk("pulse_hold1", 1'b0, 1'b1, 6'd21);
    step();
    chk("pulse_hold2", 1'b0, 1'b1, 6'd21);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 32'hFF005A1F);
    step();
    drive(1'b1, 1'b0, 32'hFFFFFFFF);
    step();
    drive(1'b0, 1'b0, '0);
    chk("mid_first_word", 1'b1, 1'b1, 6'd17);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_clear", 1'b0, 1'b0, 6'd0);
    step();
    #2 rst_n = 1'b1;
    step();
    step();
    chk("mid_second_lost", 1'b0, 1'b0, 6'd0);
    step();
    chk("mid_still_idle", 1'b0, 1'b0, 6'd0);
  endtask

`ifdef ODD_SEL_STICKY_ERR_EN
  task automatic chk_sticky(input string name, input logic want);
    n_cmp++;
    if (err_sticky !== want) begin
      n_err++;
      $display("FAIL %s: got err_sticky=%b want %b", name, err_sticky, want);
    end
  endtask

  task automatic test_sticky();
    drive(1'b1, 1'b1, 32'hFF825A5F);
    step();
    drive(1'b1, 1'b1, 32'hFF005A1F);
    step();
    chk("sticky_fail_out", 1'b1, 1'b0, 6'd20);
    chk_sticky("sticky_before_set", 1'b0);
    drive(1'b1, 1'b1, 32'hFF265A6F);
    step();
    chk_sticky("sticky_set", 1'b1);
    drive(1'b0, 1'b0, '0);
    repeat (3) step();
    chk_sticky("sticky_held", 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk_sticky("sticky_cleared", 1'b0);
    drive(1'b1, 1'b1, 32'hFF825A5F);
    step();
    drive(1'b0, 1'b0, '0);
    step();
    chk("sticky_fail_again", 1'b1, 1'b0, 6'd20);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk_sticky("sticky_clr_priority", 1'b0);
    step();
    chk_sticky("sticky_stays_clear", 1'b0);
  endtask
`endif

  initial begin
    drive(1'b0, 1'b0, '0);
    test_reset();
    test_single();
    test_back_to_back();
    test_boundary();
    test_pulse_hold();
    test_reset_mid();
`ifdef ODD_SEL_STICKY_ERR_EN
    test_sticky();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/odd_sel.md
Name: odd_sel

Overview:
Registered, selectable-polarity parity checker for a DATA_W-bit word.
- Reports whether the word's count of 1s matches the selected parity: sel=1 → odd, sel=0 → even.
- Also reports the raw count of 1s (popcount).
- Sits on a datapath boundary as a pipelined integrity check with a fixed 2-cycle latency and valid tagging.

Parameters:
- DATA_W, 32, data word width (≥2).
- CNT_W, $clog2(DATA_W+1), popcount output width (6 for 32).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- data  in  DATA_W  word under check.
- sel  in  1  parity select: 1 = expect odd number of 1s, 0 = expect even number of 1s.
- in_valid  in  1  data/sel qualifier; sampled every clk.
- check  out  1  1 = word matches the selected parity.
- ones_cnt  out  CNT_W  number of 1s in the word.
- out_valid  out  1  check/ones_cnt qualifier.

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous release): all pipeline registers clear; out_valid=0, check=0, ones_cnt=0.
- Stage 1 (edge N):
  - Register the per-byte popcounts and per-byte XOR parities of data (groups of 8 bits; last group partial if DATA_W%8≠0).
  - Register sel and in_valid alongside them.
- Stage 2 (edge N+1):
  - ones_cnt = sum of the byte popcounts.
  - par = XOR of the byte parities.
  - check = sel ? par : ~par.
  - out_valid = stage-1 valid.
- Latency: inputs sampled at edge N appear on the outputs after edge N+1 (2 cycles).
- Throughput: one word per cycle; no backpressure.
- When in_valid=0:
  - Pipeline still advances; out_valid goes 0 two cycles later.
  - check and ones_cnt hold their last valid values, i.e. data registers load only when the valid bit is 1.
- sel is carried with its word. Changing sel mid-stream affects only words sampled with the new value.
- Boundaries:
  - data=0: ones_cnt=0, even; check=1 when sel=0.
  - data all ones: ones_cnt=DATA_W; parity = DATA_W mod 2.
- Reset asserted mid-operation: in-flight words are discarded; outputs return to reset values immediately.
- Outputs are purely registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: ODD_SEL_STICKY_ERR_EN.
- When defined, add two ports:
  - err_clr  in  1
  - err_sticky  out  1
- err_sticky behaviour:
  - Set on the cycle after out_valid=1 with check=0.
  - Stays set until err_clr=1 is sampled; err_clr has priority over a simultaneous set.
  - Reset value 0.
- When undefined: those ports and the logic are absent; behaviour is otherwise identical.

Test Plan:
- sel=1, in_valid=1, data=32'hFF005A1F → 2 cycles later: ones_cnt=17, check=1, out_valid=1.
- sel=1, data=32'hFF825A5F → ones_cnt=20, check=0. Then 32'hFF265A6F → 21, check=1. Then 32'hFF415A8F → 19, check=1.
- sel=0 with the same four words back-to-back → check 0,1,0,0 on consecutive cycles; ones_cnt unchanged from the sel=1 run.
- data=0 → ones_cnt=0; check=1 for sel=0, check=0 for sel=1. data=32'hFFFFFFFF → ones_cnt=32, same check results as data=0.
- Single-cycle in_valid pulse, then in_valid=0 → out_valid high for exactly one cycle, outputs hold afterwards. Pull rst_n low between two valid words → outputs clear asynchronously and the second word is lost.
- With ODD_SEL_STICKY_ERR_EN:
  - A failing word (sel=1, data=32'hFF825A5F) sets err_sticky; it stays set through later passing words.
  - err_clr=1 clears it; simultaneous fail plus err_clr leaves it 0.
